lf_cap_cal_ctrl: RTL

- Digital SAR calibration controller for the CDR loop-filter capacitor bank, which is built from switchable EEnet capacitor cells.
- Per trial code, the controller sequences the bank in a fixed order: discharge, constant-current ramp, settle, then sample an external comparator (cap voltage vs. reference).
- It resolves the trim code MSB-first and holds the final code on the bank select lines.
- It sits between the loop-filter analog model and the CDR configuration/startup logic.

---
 rtl/lf_cap_cal_ctrl_if.sv | 26 ++
 rtl/lf_cap_cal_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/lf_cap_cal_ctrl_if.sv
// Bus between the CDR startup/config logic (master) and the loop-filter
// capacitor calibration controller (slave).
interface lf_cap_cal_ctrl_if #(
    parameter int NBITS = 4
);
    logic             start;
    logic             cmp_hi;
    logic             ovr_en;
    logic [NBITS-1:0] ovr_code;
    logic [NBITS-1:0] cap_trim;
    logic             dis_en;
    logic             chg_en;
    logic             busy;
    logic             done;
    logic             cal_valid;

    modport master (
        output start, cmp_hi, ovr_en, ovr_code,
        input  cap_trim, dis_en, chg_en, busy, done, cal_valid
    );

    modport slave (
        input  start, cmp_hi, ovr_en, ovr_code,
        output cap_trim, dis_en, chg_en, busy, done, cal_valid
    );
endinterface

// File: rtl/lf_cap_cal_ctrl.sv
// SAR calibration controller for the CDR loop-filter capacitor bank.
// Each trial code is exercised as discharge -> constant-current ramp ->
// settle -> comparator sample; the code is resolved MSB-first and the final
// value is held on cap_trim. All outputs are registered.
module lf_cap_cal_ctrl #(
    parameter int               NBITS      = 4,
    parameter int               DISCH_CYC  = 2,
    parameter int               RAMP_CYC   = 8,
    parameter int               SETTLE_CYC = 1,
    parameter logic [NBITS-1:0] TRIM_RST   = 4'b1000
) (
    input  logic              ck,
    input  logic              rst_n,
    lf_cap_cal_ctrl_if.slave  bus
);
    localparam int MAX_AB = (DISCH_CYC > RAMP_CYC) ? DISCH_CYC : RAMP_CYC;
    localparam int MAXC   = (MAX_AB > SETTLE_CYC) ? MAX_AB : SETTLE_CYC;
    // Counter holds (phase length - 1) and counts down to zero, so it only
    // needs to represent MAXC-1.
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IDXW   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [NBITS-1:0] TRIM_MSB = NBITS'(1) << (NBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DISCH,
        CHARGE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [NBITS-1:0]  trim_reg;
    logic              dis_en_reg;
    logic              chg_en_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cal_valid_reg;
    logic [NBITS-1:0]  trim_next;

    // Code after a SAMPLE: current trial bit takes the comparator result, the
    // next-lower bit (if any) is raised as the following trial bit.
    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_trim
            if (gi < NBITS - 1) begin : g_lower
                assign trim_next[gi] = (idx_reg == IDXW'(gi))     ? bus.cmp_hi :
                                       (idx_reg == IDXW'(gi + 1)) ? 1'b1       :
                                                                    trim_reg[gi];
            end else begin : g_top
                assign trim_next[gi] = (idx_reg == IDXW'(gi)) ? bus.cmp_hi : trim_reg[gi];
            end
        end
    endgenerate

    // Calibration sequencer; every output is updated alongside the state so
    // that it is valid in the same cycle the state becomes current.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= IDXW'(NBITS - 1);
            trim_reg      <= TRIM_RST;
            dis_en_reg    <= 1'b0;
            chg_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cal_valid_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.ovr_en) begin
                        trim_reg <= bus.ovr_code;
                    end else if (bus.start) begin
                        state_reg     <= DISCH;
                        busy_reg      <= 1'b1;
                        cal_valid_reg <= 1'b0;
                        idx_reg       <= IDXW'(NBITS - 1);
                        trim_reg      <= TRIM_MSB;
                        dis_en_reg    <= 1'b1;
                        cnt_reg       <= CW'(DISCH_CYC - 1);
                    end
                end
                DISCH: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= CHARGE;
                        dis_en_reg <= 1'b0;
                        chg_en_reg <= 1'b1;
                        cnt_reg    <= CW'(RAMP_CYC - 1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                CHARGE: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= SETTLE;
                        chg_en_reg <= 1'b0;
                        cnt_reg    <= CW'(SETTLE_CYC - 1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                SAMPLE: begin
                    trim_reg <= trim_next;
                    if (idx_reg != '0) begin
                        idx_reg    <= idx_reg - 1'b1;
                        state_reg  <= DISCH;
                        dis_en_reg <= 1'b1;
                        cnt_reg    <= CW'(DISCH_CYC - 1);
                    end else begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    cal_valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.cap_trim  = trim_reg;
    assign bus.dis_en    = dis_en_reg;
    assign bus.chg_en    = chg_en_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.cal_valid = cal_valid_reg;

endmodule
